seq_pattern_ctrl: RTL and testbench

- Programmable sequence controller that replays a stored table of output codes, one entry per accepted transfer.
- Generalises the fixed 3-bit arbitrary-sequence counter. Adds a writable pattern table, programmable length, one-shot/repeat mode, start/stop control and a valid/ready output handshake.
- Sits between a configuration master (cfg_* port) and a downstream consumer of the code stream.

---
 rtl/seq_pattern_pkg.sv | 34 +++
 rtl/seq_pattern_table.sv | 39 +++
 rtl/seq_pattern_ctrl.sv | 147 ++++++++++++++
 tb/tb_seq_pattern_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_pkg.sv
// -----------------------------------------------------------------------------
// seq_pattern_pkg
// Shared types and constants for the programmable sequence controller.
//   state_t          : controller FSM states (IDLE, RUN, DONE)
//   DEFAULT_PATTERN  : power-on / reset contents of the pattern table
//   DEFAULT_LEN      : power-on / reset latched sequence length
//   default_code()   : reset value of table entry idx (0 beyond the pattern)
// -----------------------------------------------------------------------------
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N   = 8;
    localparam int DEFAULT_LEN = 7;

    // Element 0 is the rightmost: sequence 0,1,2,3,6,5,7,0.
    localparam logic [DEFAULT_N-1:0][2:0] DEFAULT_PATTERN = {
        3'd0, 3'd7, 3'd5, 3'd6, 3'd3, 3'd2, 3'd1, 3'd0
    };

    function automatic logic [2:0] default_code(input int idx);
        logic [2:0] sel;
        sel = idx[2:0];
        if (idx >= 0 && idx < DEFAULT_N) begin
            return DEFAULT_PATTERN[sel];
        end
        return 3'd0;
    endfunction

endpackage

// File: rtl/seq_pattern_table.sv
// -----------------------------------------------------------------------------
// seq_pattern_table
// DEPTH x WIDTH register file holding the output code pattern.
// Ports:
//   clock, reset : clock and synchronous active-high reset (restores default)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : asynchronous (combinational) read port
// -----------------------------------------------------------------------------
module seq_pattern_table
    import seq_pattern_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(default_code(i));
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/seq_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// seq_pattern_ctrl
// Programmable sequence controller: replays the pattern table one entry per
// accepted transfer, in one-shot or repeat mode.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data : table write (honoured only while busy=0)
//   cfg_len, cfg_repeat    : sequence length (1..DEPTH) and repeat mode,
//                            latched on an accepted start
//   start, stop            : begin (from IDLE) / abort sequence
//   out_valid/out_ready    : output handshake; out_value/out_index payload
//   busy                   : high while running
//   done                   : one-cycle pulse at the end of a one-shot pass
//   loop_count             : completed-pass counter, saturating, only when
//                            SEQ_PATTERN_CTRL_LOOPCNT_EN is defined
// -----------------------------------------------------------------------------
module seq_pattern_ctrl
    import seq_pattern_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [AW:0]      cfg_len,
    input  logic             cfg_repeat,
    input  logic             start,
    input  logic             stop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [AW-1:0]    out_index,
    output logic             busy,
`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
    output logic [15:0]      loop_count,
`endif
    output logic             done
);

    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    state_t        state;
    logic [AW-1:0] index;
    logic [AW:0]   len_q;
    logic          rep_q;

    logic tbl_we;
    logic len_ok;
    logic accept;
    logic last;

    // Writes are locked out while the sequence is running so the stream
    // being emitted can never change under the consumer.
    assign tbl_we = cfg_we & ~busy;
    assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    assign accept = out_valid & out_ready;
    assign last   = ({1'b0, index} == (len_q - LEN_ONE));

    seq_pattern_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clock (clock),
        .reset (reset),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (index),
        .rdata (out_value)
    );

    assign out_index = index;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            len_q     <= (AW+1)'(DEFAULT_LEN);
            rep_q     <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
            loop_count <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop && len_ok) begin
                        state     <= RUN;
                        index     <= '0;
                        len_q     <= cfg_len;
                        rep_q     <= cfg_repeat;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
                        loop_count <= '0;
`endif
                    end
                end
                RUN: begin
                    // stop wins over a simultaneous handshake.
                    if (stop) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (accept) begin
                        if (last) begin
`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
                            if (loop_count != 16'hFFFF) begin
                                loop_count <= loop_count + 16'd1;
                            end
`endif
                            if (rep_q) begin
                                index <= '0;
                            end else begin
                                state     <= DONE;
                                out_valid <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end
                        end else begin
                            index <= index + IDX_ONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_ctrl
// Self-checking bench for seq_pattern_ctrl. A behavioural model (run flag,
// position, table array) predicts the outputs every cycle. Define
// SEQ_PATTERN_CTRL_LOOPCNT_EN to also cover loop_count.
// -----------------------------------------------------------------------------
module tb_seq_pattern_ctrl;

    localparam int WIDTH = 3;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DEF [8] = '{0, 1, 2, 3, 6, 5, 7, 0};

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [WIDTH-1:0] cfg_data = '0;
    logic [AW:0]      cfg_len = '0;
    logic             cfg_repeat = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_value;
    logic [AW-1:0]    out_index;
    logic             busy;
    logic             done;
`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
    logic [15:0]      loop_count;
`endif

    always #5 clock = ~clock;

    seq_pattern_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_len    (cfg_len),
        .cfg_repeat (cfg_repeat),
        .start      (start),
        .stop       (stop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_value  (out_value),
        .out_index  (out_index),
        .busy       (busy),
`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
        .loop_count (loop_count),
`endif
        .done       (done)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model
    int m_tbl [DEPTH];
    bit m_run;
    bit m_done;
    int m_pos;
    int m_len;
    bit m_rep;
    int m_loops;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = (i < 8) ? DEF[i] : 0;
        m_run = 0; m_done = 0; m_pos = 0; m_len = 7; m_rep = 1; m_loops = 0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_step();
        bit next_done;
        next_done = 0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_run) begin
            if (stop) begin
                m_run = 0;
            end else if (out_ready) begin
                if (m_pos == m_len - 1) begin
                    if (m_loops < 65535) m_loops++;
                    if (m_rep) m_pos = 0;
                    else begin m_run = 0; next_done = 1; end
                end else begin
                    m_pos++;
                end
            end
        end else begin
            if (cfg_we) m_tbl[cfg_addr] = int'(cfg_data);
            if (!m_done && start && !stop && int'(cfg_len) >= 1 && int'(cfg_len) <= DEPTH) begin
                m_run = 1; m_pos = 0; m_len = int'(cfg_len); m_rep = cfg_repeat; m_loops = 0;
            end
        end
        m_done = next_done;
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        cfg_we = 0; start = 0; stop = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1; cyc(); cyc(); reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({out_valid, busy, done, out_index, out_value} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b b=%b d=%b idx=%0d val=%0d want all 0",
                     out_valid, busy, done, out_index, out_value);
        end
`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
        total++;
        if (loop_count !== 16'd0) begin
            bad++; $display("FAIL reset_loop_count got %0d want 0", loop_count);
        end
`endif
    endtask

    task automatic test_default_repeat();
        int k;
        do_reset();
        cfg_len = 4'd7; cfg_repeat = 1; start = 1; out_ready = 1;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            total++;
            if (out_valid !== m_run || busy !== m_run || done !== m_done ||
                (m_run && (out_index !== AW'(m_pos) || out_value !== WIDTH'(m_tbl[m_pos])))) begin
                bad++;
                $display("FAIL default_model c=%0d got v=%b b=%b d=%b idx=%0d val=%0d want v=%b d=%b idx=%0d val=%0d",
                         c, out_valid, busy, done, out_index, out_value, m_run, m_done, m_pos, m_tbl[m_pos]);
            end
            total++;
            if (out_valid !== 1'b1 || done !== 1'b0 || out_index !== AW'(k % 7) || out_value !== WIDTH'(DEF[k % 7])) begin
                bad++;
                $display("FAIL default_seq k=%0d got v=%b d=%b idx=%0d val=%0d want v=1 d=0 idx=%0d val=%0d",
                         k, out_valid, done, out_index, out_value, k % 7, DEF[k % 7]);
            end
            k++;
        end
        quiet(); stop = 1; cyc(); stop = 0;
    endtask

    task automatic test_oneshot();
        int pats [4] = '{5, 4, 3, 2};
        int dones;
        int vals [$];
        do_reset();
        for (int a = 1; a < 4; a++) begin
            cfg_we = 1; cfg_addr = AW'(a); cfg_data = WIDTH'(pats[a]); cyc();
        end
        // entry 0 written in the same cycle as start
        cfg_addr = '0; cfg_data = WIDTH'(pats[0]);
        cfg_len = 4'd4; cfg_repeat = 0; start = 1; cyc();
        cfg_we = 0; start = 0; out_ready = 1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid === 1'b1) vals.push_back(int'(out_value));
            cyc();
            if (done === 1'b1) dones++;
            total++;
            if (out_valid !== m_run || busy !== m_run || done !== m_done ||
                (m_run && (out_index !== AW'(m_pos) || out_value !== WIDTH'(m_tbl[m_pos])))) begin
                bad++;
                $display("FAIL oneshot_model c=%0d got v=%b b=%b d=%b idx=%0d val=%0d want v=%b d=%b idx=%0d val=%0d",
                         c, out_valid, busy, done, out_index, out_value, m_run, m_done, m_pos, m_tbl[m_pos]);
            end
        end
        total++;
        if (dones != 1 || vals.size() != 4) begin
            bad++; $display("FAIL oneshot_counts got done=%0d n=%0d want done=1 n=4", dones, vals.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (vals[i] != pats[i]) begin
                    bad++; $display("FAIL oneshot_value i=%0d got %0d want %0d", i, vals[i], pats[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit rdy [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        do_reset();
        cfg_len = 4'd7; cfg_repeat = 1; start = 1; cyc(); start = 0;
        for (int c = 0; c < 9; c++) begin
            out_ready = rdy[c];
            cyc();
            total++;
            if (out_valid !== m_run || busy !== m_run || done !== m_done ||
                (m_run && (out_index !== AW'(m_pos) || out_value !== WIDTH'(m_tbl[m_pos])))) begin
                bad++;
                $display("FAIL bp_model c=%0d got v=%b idx=%0d val=%0d want v=%b idx=%0d val=%0d",
                         c, out_valid, out_index, out_value, m_run, m_pos, m_tbl[m_pos]);
            end
            if (c >= 1 && c <= 4) begin
                total++;
                if (out_index !== 3'd2 || out_value !== 3'd2) begin
                    bad++; $display("FAIL bp_hold c=%0d got idx=%0d val=%0d want idx=2 val=2", c, out_index, out_value);
                end
            end
            if (c == 5) begin
                total++;
                if (out_index !== 3'd3 || out_value !== 3'd3) begin
                    bad++; $display("FAIL bp_release got idx=%0d val=%0d want idx=3 val=3", out_index, out_value);
                end
            end
        end
        quiet(); stop = 1; cyc(); stop = 0;
    endtask

    task automatic test_stop();
        do_reset();
        cfg_len = 4'd7; cfg_repeat = 1; start = 1; cyc(); start = 0;
        out_ready = 1;
        for (int c = 0; c < 4; c++) cyc();
        total++;
        if (out_index !== 3'd4) begin
            bad++; $display("FAIL stop_setup got idx=%0d want 4", out_index);
        end
        stop = 1; cyc(); stop = 0; out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_run || m_done) begin
                bad++; $display("FAIL stop_idle c=%0d got v=%b b=%b d=%b want 0 0 0", c, out_valid, busy, done);
            end
            cyc();
        end
        start = 1; cyc(); start = 0;
        total++;
        if (out_valid !== 1'b1 || out_index !== 3'd0 || out_value !== 3'd0) begin
            bad++; $display("FAIL stop_restart got v=%b idx=%0d val=%0d want v=1 idx=0 val=0", out_valid, out_index, out_value);
        end
        stop = 1; cyc(); stop = 0;
    endtask

    task automatic test_busy_write_and_len();
        int seen;
        do_reset();
        cfg_len = 4'd7; cfg_repeat = 1; start = 1; cyc(); start = 0;
        cfg_we = 1; cfg_addr = 3'd1; cfg_data = 3'd7; cyc(); cfg_we = 0;
        out_ready = 1; cyc();
        total++;
        if (out_index !== 3'd1 || out_value !== 3'd1 || m_tbl[1] != 1) begin
            bad++; $display("FAIL busy_write got idx=%0d val=%0d want idx=1 val=1", out_index, out_value);
        end
        quiet(); stop = 1; cyc(); stop = 0;
        // out-of-range lengths are ignored
        for (int t = 0; t < 3; t++) begin
            cfg_len = (t == 0) ? 4'd0 : (t == 1) ? 4'd9 : 4'd15;
            start = 1; cyc(); start = 0; cyc();
            total++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                bad++; $display("FAIL bad_len len=%0d got busy=%b v=%b want 0 0", cfg_len, busy, out_valid);
            end
        end
        // full-length one-shot
        cfg_len = 4'd8; cfg_repeat = 0; start = 1; cyc(); start = 0; out_ready = 1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid === 1'b1 && out_index === 3'd7) begin
                seen++;
                total++;
                if (out_value !== 3'd0) begin
                    bad++; $display("FAIL len8_last got %0d want 0", out_value);
                end
            end
            cyc();
            total++;
            if (out_valid !== m_run || busy !== m_run || done !== m_done) begin
                bad++; $display("FAIL len8_model c=%0d got v=%b d=%b want v=%b d=%b", c, out_valid, done, m_run, m_done);
            end
        end
        total++;
        if (seen != 1) begin
            bad++; $display("FAIL len8_reach got %0d visits to index 7 want 1", seen);
        end
        quiet();
    endtask

`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
    task automatic test_loopcnt();
        do_reset();
        cfg_len = 4'd8; cfg_repeat = 1; start = 1; cyc(); start = 0; out_ready = 1;
        for (int c = 0; c < 24; c++) cyc();
        total++;
        if (loop_count !== 16'd3) begin
            bad++; $display("FAIL loopcnt_three got %0d want 3", loop_count);
        end
        quiet(); stop = 1; cyc(); stop = 0;
        start = 1; cyc(); start = 0;
        total++;
        if (loop_count !== 16'd0) begin
            bad++; $display("FAIL loopcnt_clear got %0d want 0", loop_count);
        end
        stop = 1; cyc(); stop = 0;
    endtask
`endif

    task automatic test_reset_midrun();
        do_reset();
        cfg_we = 1; cfg_addr = 3'd0; cfg_data = 3'd6; cyc(); cfg_we = 0;
        cfg_len = 4'd5; cfg_repeat = 1; start = 1; cyc(); start = 0; out_ready = 1;
        cyc(); cyc();
        reset = 1; cyc(); reset = 0; out_ready = 0;
        total++;
        if ({out_valid, busy, done, out_index, out_value} !== '0) begin
            bad++; $display("FAIL midrun_reset got v=%b b=%b idx=%0d val=%0d want all 0", out_valid, busy, out_index, out_value);
        end
        start = 1; cfg_len = 4'd3; cyc(); start = 0;
        total++;
        if (out_valid !== 1'b1 || out_value !== 3'd0) begin
            bad++; $display("FAIL midrun_table got v=%b val=%0d want v=1 val=0", out_valid, out_value);
        end
        stop = 1; cyc(); stop = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 499) == 0);
            cfg_we     = ($urandom_range(0, 3) == 0);
            cfg_addr   = AW'($urandom_range(0, DEPTH - 1));
            cfg_data   = WIDTH'($urandom_range(0, 7));
            cfg_len    = (AW+1)'($urandom_range(0, 10));
            cfg_repeat = $urandom_range(0, 1) != 0;
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 19) == 0);
            out_ready  = $urandom_range(0, 1) != 0;
            cyc();
            total++;
            if (out_valid !== m_run || busy !== m_run || done !== m_done ||
                (m_run && (out_index !== AW'(m_pos) || out_value !== WIDTH'(m_tbl[m_pos])))) begin
                bad++;
                $display("FAIL random c=%0d got v=%b b=%b d=%b idx=%0d val=%0d want v=%b d=%b idx=%0d val=%0d",
                         c, out_valid, busy, done, out_index, out_value, m_run, m_done, m_pos, m_tbl[m_pos]);
            end
`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
            total++;
            if (loop_count !== 16'(m_loops)) begin
                bad++; $display("FAIL random_loopcnt c=%0d got %0d want %0d", c, loop_count, m_loops);
            end
`endif
        end
        reset = 0;
        quiet();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_repeat();
        test_oneshot();
        test_backpressure();
        test_stop();
        test_busy_write_and_len();
`ifdef SEQ_PATTERN_CTRL_LOOPCNT_EN
        test_loopcnt();
`endif
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
